// File: rtl/dmem_pkg.sv
// Shared types and address-check helper for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  // Returns {misaligned, out_of_range}; addresses below base wrap to huge offsets.
  function automatic logic [1:0] addr_ok(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input int          depth);
    logic [31:0] off;
    logic [31:0] lim;
    off = addr - base;
    lim = 32'(depth) * 32'(WORD_BYTES);
    return {addr[1:0] != 2'b00, off >= lim};
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store port between the processor datapath and the memory responder.
interface dmem_if;
  logic        MemReq;
  logic        MemWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemReady;
  logic        MemErr;
  logic        Busy;

  modport master (
    output MemReq, MemWrite, Addr, WriteData,
    input  ReadData, MemReady, MemErr, Busy
  );

  modport slave (
    input  MemReq, MemWrite, Addr, WriteData,
    output ReadData, MemReady, MemErr, Busy
  );
endinterface

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; registered read, no reset on contents.
module dmem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wd,
  output logic [31:0]      rd
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= wd;
    end
    rd <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Word RAM responder with programmable wait states, alignment and range checks.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS4   = 4'(WAIT_STATES);

  state_t           state;
  state_t           state_next;
  logic [3:0]       cnt;
  logic [3:0]       cnt_next;
  logic             capture;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             write_q;
  logic [1:0]       chk;
  logic             bad;
  logic [31:0]      idx_src;
  logic [IDX_W-1:0] idx;
  logic             we;
  logic [31:0]      rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        addr_q  <= bus.Addr;
        wdata_q <= bus.WriteData;
        write_q <= bus.MemWrite;
      end
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MemReq) begin
          capture    = 1'b1;
          cnt_next   = WS4;
          state_next = (WAIT_STATES > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign chk = addr_ok(addr_q, BASE_ADDR, DEPTH_WORDS);
  assign bad = |chk;

  // With zero wait states the RAM read happens on the accepting edge, so the
  // index must come straight from the bus in that cycle.
  assign idx_src = (capture ? bus.Addr : addr_q) - BASE_ADDR;
  assign idx     = IDX_W'(idx_src >> 2);
  assign we      = (state == RESP) && write_q && !bad;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk (clk),
    .we  (we),
    .idx (idx),
    .wd  (wdata_q),
    .rd  (rd)
  );

  assign bus.MemReady = (state == RESP);
  assign bus.MemErr   = (state == RESP) && bad;
  assign bus.Busy     = (state != IDLE);
  assign bus.ReadData = ((state == RESP) && !write_q && !bad) ? rd : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders (wait states 1, 0, 3) against a word-array model.
module tb_dmem_responder;

  localparam int N = 3;

  typedef struct {
    int          k;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic reset;

  logic        req   [N];
  logic        wr    [N];
  logic [31:0] addr  [N];
  logic [31:0] wdata [N];
  logic [31:0] rdata [N];
  logic        ready [N];
  logic        err   [N];
  logic        busy  [N];

  int          ws_of   [N] = '{1, 0, 3};
  logic [31:0] base_of [N] = '{32'h0, 32'h0, 32'h0000_1000};

  logic [31:0] model_mem [N][64];
  exp_t        exp_q[$];
  bit          in_resp [N];
  int          sel;
  int          checks;
  int          passes;

  dmem_if bus0 ();
  dmem_if bus1 ();
  dmem_if bus2 ();

  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(1), .BASE_ADDR(32'h0))
    dut0 (.clk(clk), .reset(reset), .bus(bus0));
  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0), .BASE_ADDR(32'h0))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));
  dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(3), .BASE_ADDR(32'h0000_1000))
    dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus0.MemReq = req[0];  assign bus0.MemWrite = wr[0];
  assign bus0.Addr   = addr[0]; assign bus0.WriteData = wdata[0];
  assign bus1.MemReq = req[1];  assign bus1.MemWrite = wr[1];
  assign bus1.Addr   = addr[1]; assign bus1.WriteData = wdata[1];
  assign bus2.MemReq = req[2];  assign bus2.MemWrite = wr[2];
  assign bus2.Addr   = addr[2]; assign bus2.WriteData = wdata[2];

  assign rdata[0] = bus0.ReadData; assign ready[0] = bus0.MemReady;
  assign err[0]   = bus0.MemErr;   assign busy[0]  = bus0.Busy;
  assign rdata[1] = bus1.ReadData; assign ready[1] = bus1.MemReady;
  assign err[1]   = bus1.MemErr;   assign busy[1]  = bus1.Busy;
  assign rdata[2] = bus2.ReadData; assign ready[2] = bus2.MemReady;
  assign err[2]   = bus2.MemErr;   assign busy[2]  = bus2.Busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got %h, want %h", name, got, want);
  endtask

  // Reference model: a plain word array indexed by byte offset from the base.
  task automatic pushExpect(input int k, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    exp_t        e;
    off = a - base_of[k];
    e.k = k;
    if (a[1:0] != 2'b00 || off >= 32'd256) begin
      e.err  = 1'b1;
      e.data = 32'h0;
    end else if (w) begin
      model_mem[k][off[7:2]] = d;
      e.err  = 1'b0;
      e.data = 32'h0;
    end else begin
      e.err  = 1'b0;
      e.data = model_mem[k][off[7:2]];
    end
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input int k, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input bit scramble);
    int edges;
    pushExpect(k, w, a, d);
    req[k] = 1'b1; wr[k] = w; addr[k] = a; wdata[k] = d;
    if (in_resp[k]) begin
      @(posedge clk); #1;
      checkOutput("ignored_in_resp_ready", 32'(ready[k]), 32'd0);
      checkOutput("gap_busy", 32'(busy[k]), 32'd0);
    end
    @(posedge clk); #1;
    checkOutput("busy_after_accept", 32'(busy[k]), 32'd1);
    edges = 0;
    while (!ready[k] && edges < 40) begin
      if (scramble) begin
        addr[k] = $urandom; wdata[k] = $urandom; wr[k] = 1'($urandom);
      end
      @(posedge clk); #1;
      edges++;
    end
    checkOutput("latency", 32'(edges), 32'(ws_of[k]));
    in_resp[k] = 1'b1;
  endtask

  task automatic idleCycles(input int k, input int n);
    req[k] = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    in_resp[k] = 1'b0;
  endtask

  function automatic logic [31:0] randAddr(input int k);
    logic [31:0] word;
    word = base_of[k] + 32'($urandom_range(0, 63)) * 32'd4;
    case ($urandom_range(0, 9))
      0:       return word + 32'($urandom_range(1, 3));
      1:       return base_of[k] + 32'h100 + 32'($urandom_range(0, 255)) * 32'd4;
      2:       return $urandom;
      default: return word;
    endcase
  endfunction

  // Monitor: pops one expectation per response on the selected instance.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        if (k != sel) begin
          checkOutput("unselected_ready", 32'(ready[k]), 32'd0);
        end else if (ready[k]) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("[TB] FAIL spurious_ready inst %0d: got response, want none", k);
          end else begin
            e = exp_q.pop_front();
            checkOutput("resp_inst", 32'(k), 32'(e.k));
            checkOutput("resp_err", 32'(err[k]), 32'(e.err));
            checkOutput("resp_rdata", rdata[k], e.data);
          end
        end else begin
          checkOutput("idle_rdata", rdata[k], 32'h0);
        end
      end
    end
  end

  initial begin
    checks = 0; passes = 0; sel = 0;
    reset = 1'b0;
    for (int k = 0; k < N; k++) begin
      req[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; wdata[k] = '0; in_resp[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      checkOutput("reset_rdata", rdata[k], 32'h0);
      checkOutput("reset_ready", 32'(ready[k]), 32'd0);
      checkOutput("reset_err", 32'(err[k]), 32'd0);
      checkOutput("reset_busy", 32'(busy[k]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Fill every instance so all later loads have known contents.
    for (int k = 0; k < N; k++) begin
      sel = k;
      for (int i = 0; i < 64; i++)
        applyStimulus(k, 1'b1, base_of[k] + 32'(i * 4), $urandom, 1'($urandom));
      idleCycles(k, 2);
    end

    sel = 0;
    applyStimulus(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'h12, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 32'h100, 32'h1234_5678, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'hFC, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 32'hFC, 32'h1, 1'b0);
    applyStimulus(0, 1'b1, 32'h0, 32'h2, 1'b0);
    applyStimulus(0, 1'b0, 32'hFC, 32'h0, 1'b0);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 1'b0);
    applyStimulus(0, 1'b1, 32'h44, 32'h5A5A_A5A5, 1'b1);
    applyStimulus(0, 1'b0, 32'h44, 32'h0, 1'b1);
    idleCycles(0, 2);

    sel = 1;
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 1'b0, 32'($urandom_range(0, 63)) * 32'd4, 32'h0, 1'b0);
    for (int i = 0; i < 60; i++)
      applyStimulus(1, 1'($urandom), randAddr(1), $urandom, 1'($urandom));
    idleCycles(1, 2);

    // Abort a store mid-wait with reset; the word must keep its old contents.
    sel = 2;
    req[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h0000_1020; wdata[2] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    checkOutput("abort_busy_after_accept", 32'(busy[2]), 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("abort_rdata", rdata[2], 32'h0);
    checkOutput("abort_ready", 32'(ready[2]), 32'd0);
    checkOutput("abort_err", 32'(err[2]), 32'd0);
    checkOutput("abort_busy", 32'(busy[2]), 32'd0);
    req[2] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    in_resp[2] = 1'b0;
    applyStimulus(2, 1'b0, 32'h0000_1020, 32'h0, 1'b0);
    applyStimulus(2, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
    applyStimulus(2, 1'b1, 32'h0000_10FC, 32'h0BAD_F00D, 1'b1);
    applyStimulus(2, 1'b0, 32'h0000_10FC, 32'h0, 1'b0);
    for (int i = 0; i < 40; i++)
      applyStimulus(2, 1'($urandom), randAddr(2), $urandom, 1'($urandom));
    idleCycles(2, 3);

    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
